// File: rtl/sprite_move_ctrl.sv
// Moves a solid SPR_W x SPR_H sprite on the plot grid: erase, step one pixel, redraw, one pixel per clock.
// Optional macro SPRITE_WRAP_EN: moves wrap at the screen edges instead of blocking.
module sprite_move_ctrl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int X_INIT   = 5,
    parameter int Y_INIT   = 5,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                up,
    input  logic                down,
    input  logic                left,
    input  logic                right,
    input  logic                stop,
    input  logic [COLOUR_W-1:0] colour,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic [X_W-1:0]      pos_x,
    output logic [Y_W-1:0]      pos_y
);

    localparam int CW     = 5;
    localparam int X_LAST = X_MAX - SPR_W + 1;
    localparam int Y_LAST = Y_MAX - SPR_H + 1;
`ifdef SPRITE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        STEP  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        REST  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    function automatic logic move_legal(input dir_t d, input logic [X_W-1:0] px,
                                        input logic [Y_W-1:0] py);
        logic in_bounds;
        case (d)
            UP:      in_bounds = (py != {Y_W{1'b0}});
            DOWN:    in_bounds = (py < Y_W'(Y_LAST));
            LEFT:    in_bounds = (px != {X_W{1'b0}});
            RIGHT:   in_bounds = (px < X_W'(X_LAST));
            default: in_bounds = 1'b0;
        endcase
        return (d != REST) && (WRAP_EN || in_bounds);
    endfunction

    function automatic logic [X_W-1:0] next_x(input dir_t d, input logic [X_W-1:0] px);
        case (d)
            LEFT:    return (px == {X_W{1'b0}}) ? X_W'(X_LAST) : px - X_W'(1);
            RIGHT:   return (WRAP_EN && px == X_W'(X_LAST)) ? {X_W{1'b0}} : px + X_W'(1);
            default: return px;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] next_y(input dir_t d, input logic [Y_W-1:0] py);
        case (d)
            UP:      return (py == {Y_W{1'b0}}) ? Y_W'(Y_LAST) : py - Y_W'(1);
            DOWN:    return (WRAP_EN && py == Y_W'(Y_LAST)) ? {Y_W{1'b0}} : py + Y_W'(1);
            default: return py;
        endcase
    endfunction

    state_t                state_r, state_next_s;
    dir_t                  dir_r, move_dir_r;
    logic [X_W-1:0]        pos_x_r;
    logic [Y_W-1:0]        pos_y_r;
    logic [CW-1:0]         cx_r, cy_r;
    logic [COLOUR_W-1:0]   colour_r;
    logic                  scan_s, last_col_s, last_px_s, tick_move_s, legal_s;
    logic                  accept_s, blocked_s;

    // Scan position and move-acceptance decode.
    always_comb begin
        scan_s      = (state_r == ERASE) || (state_r == DRAW);
        last_col_s  = (cx_r == CW'(SPR_W - 1));
        last_px_s   = scan_s && last_col_s && (cy_r == CW'(SPR_H - 1));
        tick_move_s = (state_r == IDLE) && tick && (dir_r != REST);
        legal_s     = move_legal(dir_r, pos_x_r, pos_y_r);
        accept_s    = tick_move_s && legal_s;
        blocked_s   = tick_move_s && !legal_s;
    end

    // FSM state register; reset lands in DRAW so the initial sprite is painted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= DRAW;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = accept_s ? ERASE : IDLE;
            ERASE:   state_next_s = last_px_s ? STEP : ERASE;
            STEP:    state_next_s = DRAW;
            DRAW:    state_next_s = last_px_s ? IDLE : DRAW;
            default: state_next_s = IDLE;
        endcase
    end

    // Direction request register: stop wins, then a blocked move clears, then buttons.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dir_r <= REST;
        end else if (stop) begin
            dir_r <= REST;
        end else if (blocked_s) begin
            dir_r <= REST;
        end else if (up) begin
            dir_r <= UP;
        end else if (down) begin
            dir_r <= DOWN;
        end else if (left) begin
            dir_r <= LEFT;
        end else if (right) begin
            dir_r <= RIGHT;
        end
    end

    // Position, scan counters and per-move captures.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pos_x_r    <= X_W'(X_INIT);
            pos_y_r    <= Y_W'(Y_INIT);
            cx_r       <= {CW{1'b0}};
            cy_r       <= {CW{1'b0}};
            colour_r   <= colour;
            move_dir_r <= REST;
        end else begin
            if (accept_s) begin
                colour_r   <= colour;
                move_dir_r <= dir_r;
            end
            if (state_r == STEP) begin
                pos_x_r <= next_x(move_dir_r, pos_x_r);
                pos_y_r <= next_y(move_dir_r, pos_y_r);
            end
            if (scan_s) begin
                if (last_col_s) begin
                    cx_r <= {CW{1'b0}};
                    cy_r <= last_px_s ? {CW{1'b0}} : cy_r + CW'(1);
                end else begin
                    cx_r <= cx_r + CW'(1);
                end
            end else begin
                cx_r <= {CW{1'b0}};
                cy_r <= {CW{1'b0}};
            end
        end
    end

    // Plot interface outputs, decoded from registered state.
    always_comb begin
        plot  = reset_n && scan_s;
        busy  = (state_r != IDLE);
        pos_x = pos_x_r;
        pos_y = pos_y_r;
        if (scan_s) begin
            x_out = pos_x_r + X_W'(cx_r);
            y_out = pos_y_r + Y_W'(cy_r);
        end else begin
            x_out = pos_x_r;
            y_out = pos_y_r;
        end
        if (state_r == DRAW) begin
            colour_out = colour_r;
        end else begin
            colour_out = {COLOUR_W{1'b0}};
        end
    end

endmodule

// File: doc/sprite_move_ctrl.md
Name: sprite_move_ctrl

Overview:
- Parametrised successor to the single-pixel cursor mover: moves a SPR_W x SPR_H solid sprite around the 160x120 VGA plot grid.
- Direction is taken from button pulses.
- Each move is paced by a rate tick. Every move erases the old sprite and redraws it one pixel-step away.
- Drives the existing plot interface (x, y, colour, plot strobe) of the VGA adapter, one pixel per clock.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row
- SPR_W, 4, sprite width in pixels (1..16)
- SPR_H, 4, sprite height in pixels (1..16)
- X_INIT, 5, reset x of sprite top-left corner
- Y_INIT, 5, reset y of sprite top-left corner
- COLOUR_W, 3, colour width

Ports:
- clock, in, 1: system clock
- reset_n, in, 1: synchronous, active-low reset
- tick, in, 1: one-cycle move-rate enable
- up, in, 1: direction request (level or pulse)
- down, in, 1: direction request
- left, in, 1: direction request
- right, in, 1: direction request
- stop, in, 1: halt movement
- colour, in, COLOUR_W: sprite draw colour
- x_out, out, X_W: pixel x to plot
- y_out, out, Y_W: pixel y to plot
- colour_out, out, COLOUR_W: pixel colour to plot
- plot, out, 1: write strobe; pixel valid this cycle
- busy, out, 1: high in ERASE/STEP/DRAW
- pos_x, out, X_W: current sprite top-left x
- pos_y, out, Y_W: current sprite top-left y

Behaviour:
- Reset: reset is synchronous and active-low, reset_n on clock. Registers reset as follows:
  - pos = (X_INIT, Y_INIT), dir = REST
  - state = DRAW with scan counters cx = cy = 0
  - colour register = colour input
- The initial sprite is painted automatically after reset. plot is gated low while reset_n = 0.
- Direction register (REST/UP/DOWN/LEFT/RIGHT):
  - Updated every cycle, independent of FSM state.
  - stop = 1 forces REST; stop has highest priority.
  - Otherwise priority is up > down > left > right.
  - With no input asserted, dir holds.
- FSM states: IDLE, ERASE, STEP, DRAW.
  - IDLE: on tick with dir != REST:
    - If the move is legal, capture colour and go to ERASE.
    - If blocked, set dir = REST and stay in IDLE.
    - tick with dir = REST does nothing.
  - ERASE: scans cx 0..SPR_W-1 (inner loop) and cy 0..SPR_H-1 (outer loop), one pixel per cycle.
    - x_out = pos_x + cx, y_out = pos_y + cy, colour_out = 0, plot = 1.
    - After pixel (SPR_W-1, SPR_H-1), go to STEP.
  - STEP: one cycle, plot = 0. pos changes by 1 in the direction latched at ERASE entry (UP: y-1, DOWN: y+1, LEFT: x-1, RIGHT: x+1). Go to DRAW.
  - DRAW: same scan as ERASE, using the new pos and colour_out = captured colour. After the last pixel, go to IDLE.
- Timing: with N = SPR_W*SPR_H, a move occupies 2N+1 cycles. The first ERASE pixel appears the cycle after the accepting tick. busy = 1 for exactly 2N+1 cycles.
- x_out, y_out, colour_out and plot are combinational from registered state. When plot = 0, x_out/y_out show pos.
- Move direction is frozen at ERASE entry. Direction or stop changes during busy only update dir, which takes effect at the next tick.
- Ticks arriving while busy are dropped, not queued.
- Legal-move bounds (non-wrap): UP needs pos_y > 0; DOWN needs pos_y < Y_MAX-SPR_H+1; LEFT needs pos_x > 0; RIGHT needs pos_x < X_MAX-SPR_W+1. The sprite never leaves the screen.
- reset_n low mid-scan aborts immediately. The next cycle restarts the initial DRAW at (X_INIT, Y_INIT). The old sprite is not erased, because the framebuffer is cleared by the system.

Optional Feature:
- Macro SPRITE_WRAP_EN.
- Defined: moves never block; the sprite wraps at the screen edges.
  - LEFT at x = 0 goes to X_MAX-SPR_W+1; RIGHT at X_MAX-SPR_W+1 goes to 0.
  - UP at y = 0 goes to Y_MAX-SPR_H+1; DOWN at Y_MAX-SPR_H+1 goes to 0.
  - dir is never auto-cleared.
- Undefined: clamp behaviour, where a blocked move sets dir = REST.

Test Plan:
- Reset release, defaults: 16 cycles of plot = 1 covering (5..8, 5..8) in raster order with colour_out = colour, then IDLE with busy = 0.
- right pulse, then tick: 16 erase pixels at x 5..8 with colour 0, 1 STEP cycle, 16 draw pixels at x 6..9; pos_x = 6; busy high for 33 cycles.
- Set pos_y = 0 via repeated up+tick, then one more tick: no plot, dir = REST, pos_y stays 0 (non-wrap). With SPRITE_WRAP_EN: pos_y becomes 116.
- tick asserted 5 cycles into a move, plus stop mid-move: the move completes exactly once, the extra tick is dropped, and dir = REST afterwards.
- up and left asserted together: dir = UP (priority check). Then reset_n = 0 during ERASE: the next cycle shows the DRAW restart at (5, 5).
